cache_port_arbiter: RTL and testbench



---
 rtl/cache_arb_pkg.sv | 30 +++
 rtl/cache_port_arbiter_rr_pick.sv | 27 ++
 rtl/cache_port_arbiter.sv | 114 +++++++++++
 tb/tb_cache_port_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types for the cache port arbiter: FSM state and the array/memory
// control bundle that each cache controller drives toward the shared port.
package cache_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // One controller's view of the tag/data/valid arrays plus CPU-wrapper lines.
    typedef struct packed {
        logic         core_wait;
        logic         D_req;
        logic [31:0]  D_addr;
        logic [31:0]  D_in;
        logic [2:0]   D_type;
        logic [5:0]   index;
        logic [14:0]  TA_in;
        logic         TA_write;
        logic         TA_read;
        logic [127:0] DA_in;
        logic         DA_write;
        logic         DA_read;
        logic         valid_read;
    } cache_port_bundle_t;

    localparam int CACHE_PORT_W         = $bits(cache_port_bundle_t);
    localparam int CACHE_ARB_DEFAULT_CH = 0;

endpackage

// File: rtl/cache_port_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req found searching upward
// from ptr with wrap. ptr = 0 gives plain lowest-index priority.
module rr_pick
    import cache_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic              any,
    output logic [ID_W-1:0]   idx
);

    always_comb begin
        any = |req;
        idx = ID_W'(CACHE_ARB_DEFAULT_CH);
        // Walk offsets from farthest to nearest so the nearest requester wins.
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            int c;
            c = int'(ptr) + off;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (req[c]) idx = ID_W'(c);
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// N-channel owner of the cache array port: zero-latency grant from IDLE,
// grant locked to the owner until its done pulse, with a hold-time watchdog.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int PAYLOAD_W = CACHE_PORT_W,
    parameter bit RR_EN     = 1'b1,
    parameter int MAX_HOLD  = 1024,
    parameter int ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_req,
    input  logic [NUM_CH-1:0]           ch_done,
    input  logic [NUM_CH*PAYLOAD_W-1:0] ch_payload,
    output logic [PAYLOAD_W-1:0]        out_payload,
    output logic                        out_valid,
    output logic [NUM_CH-1:0]           grant,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_e        state;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   pick_ptr;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   next_ptr;
    logic [ID_W-1:0]   sel;
    logic              win_any;
    logic [HOLD_W-1:0] hold_cnt;
    logic              timeout_q;
    logic              hold_hit;

    assign pick_ptr = RR_EN ? rr_ptr : '0;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_pick (
        .req (ch_req),
        .ptr (pick_ptr),
        .any (win_any),
        .idx (win_idx)
    );

    // Explicit wrap keeps rr_ptr in range for non-power-of-two NUM_CH.
    assign next_ptr = (win_idx == ID_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;

    // Grant is combinational; held in reset so nothing leaks while rst is high.
    always_comb begin
        sel       = ID_W'(CACHE_ARB_DEFAULT_CH);
        out_valid = 1'b0;
        grant     = '0;
        if (!rst) begin
            if (state == ARB_LOCKED) begin
                sel       = owner;
                out_valid = 1'b1;
            end else if (win_any) begin
                sel       = win_idx;
                out_valid = 1'b1;
            end
        end
        if (out_valid) grant[sel] = 1'b1;
    end

    assign grant_id = sel;
    assign busy     = (state == ARB_LOCKED);

    always_comb begin
        out_payload = ch_payload[0 +: PAYLOAD_W];
        for (int i = 1; i < NUM_CH; i++) begin
            if (sel == ID_W'(i)) out_payload = ch_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    // hold_cnt is 0 in the first LOCKED cycle, so hold_cnt+1 is the cycle count.
    assign hold_hit    = (MAX_HOLD != 0) && (state == ARB_LOCKED) &&
                         ((int'(hold_cnt) + 1) >= MAX_HOLD);
    assign timeout_err = timeout_q | hold_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (hold_hit) timeout_q <= 1'b1;
            case (state)
                ARB_IDLE: begin
                    if (win_any) begin
                        owner    <= win_idx;
                        rr_ptr   <= next_ptr;
                        hold_cnt <= '0;
                        // A done in the grant cycle completes a one-beat transaction.
                        if (!ch_done[win_idx]) state <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (int'(hold_cnt) < MAX_HOLD) hold_cnt <= hold_cnt + 1'b1;
                    if (ch_done[owner]) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed scoreboard bench for cache_port_arbiter: a round-robin instance and
// a fixed-priority instance share inputs; each expectation names its instance.
module tb_cache_port_arbiter;

    localparam int NCH = 3;
    localparam int PW  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    ch_req = '0;
    logic [NCH-1:0]    ch_done = '0;
    logic [NCH*PW-1:0] ch_payload = {8'hA2, 8'hA1, 8'hA0};

    logic [PW-1:0]  rr_pay, fp_pay;
    logic           rr_vld, fp_vld;
    logic [NCH-1:0] rr_gnt, fp_gnt;
    logic [1:0]     rr_gid, fp_gid;
    logic           rr_busy, fp_busy;
    logic           rr_to, fp_to;

    always #5 clk = ~clk;

    cache_port_arbiter #(.NUM_CH(NCH), .PAYLOAD_W(PW), .RR_EN(1'b1), .MAX_HOLD(8)) dut_rr (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_done(ch_done), .ch_payload(ch_payload),
        .out_payload(rr_pay), .out_valid(rr_vld), .grant(rr_gnt), .grant_id(rr_gid),
        .busy(rr_busy), .timeout_err(rr_to)
    );

    cache_port_arbiter #(.NUM_CH(NCH), .PAYLOAD_W(PW), .RR_EN(1'b0), .MAX_HOLD(8)) dut_fp (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_done(ch_done), .ch_payload(ch_payload),
        .out_payload(fp_pay), .out_valid(fp_vld), .grant(fp_gnt), .grant_id(fp_gid),
        .busy(fp_busy), .timeout_err(fp_to)
    );

    typedef struct {
        string       name;
        bit          fp;
        logic [15:0] vec;   // {grant, grant_id, valid, payload, busy, timeout}
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [1:0] idx_of(input logic [2:0] g);
        if (g[2]) return 2'd2;
        if (g[1]) return 2'd1;
        return 2'd0;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must show this cycle.
    task automatic cyc(input logic r, input logic [2:0] req, input logic [2:0] done,
                       input string nm, input logic [2:0] eg, input logic [7:0] ep,
                       input logic eb, input logic et, input bit fp);
        exp_t e;
        rst     = r;
        ch_req  = req;
        ch_done = done;
        e.name  = nm;
        e.fp    = fp;
        e.vec   = {eg, idx_of(eg), |eg, ep, eb, et};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                logic [15:0] got;
                e = exp_q.pop_front();
                got = e.fp ? {fp_gnt, fp_gid, fp_vld, fp_pay, fp_busy, fp_to}
                           : {rr_gnt, rr_gid, rr_vld, rr_pay, rr_busy, rr_to};
                n_tests++;
                if (got !== e.vec) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b id=%0d vld=%b pay=%h busy=%b to=%b, want gnt=%b id=%0d vld=%b pay=%h busy=%b to=%b",
                             e.name, got[15:13], got[12:11], got[10], got[9:2], got[1], got[0],
                             e.vec[15:13], e.vec[12:11], e.vec[10], e.vec[9:2], e.vec[1], e.vec[0]);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset and idle
        cyc(1, 3'b110, 3'b000, "reset_gated",  3'b000, 8'hA0, 0, 0, 0);
        cyc(0, 3'b000, 3'b000, "idle_noreq",   3'b000, 8'hA0, 0, 0, 0);
        // Zero-latency grant, then lock ignores request changes
        cyc(0, 3'b110, 3'b000, "idle_grant",   3'b010, 8'hA1, 0, 0, 0);
        cyc(0, 3'b100, 3'b000, "locked_hold",  3'b010, 8'hA1, 1, 0, 0);
        cyc(0, 3'b000, 3'b000, "req_dropped",  3'b010, 8'hA1, 1, 0, 0);
        cyc(0, 3'b111, 3'b010, "done_beat",    3'b010, 8'hA1, 1, 0, 0);
        // Rotation 2,0,1 with all requesting
        cyc(0, 3'b111, 3'b000, "rr_ch2",       3'b100, 8'hA2, 0, 0, 0);
        cyc(0, 3'b111, 3'b100, "rr_ch2_done",  3'b100, 8'hA2, 1, 0, 0);
        cyc(0, 3'b111, 3'b001, "rr_ch0_1beat", 3'b001, 8'hA0, 0, 0, 0);
        cyc(0, 3'b111, 3'b000, "rr_ch1",       3'b010, 8'hA1, 0, 0, 0);
        cyc(0, 3'b000, 3'b010, "rr_ch1_done",  3'b010, 8'hA1, 1, 0, 0);
        // Lock on channel 0, foreign done ignored, watchdog
        cyc(0, 3'b001, 3'b000, "grant_ch0",    3'b001, 8'hA0, 0, 0, 0);
        cyc(0, 3'b000, 3'b100, "foreign_done", 3'b001, 8'hA0, 1, 0, 0);
        for (int k = 2; k <= 8; k++)
            cyc(0, 3'b000, 3'b000, $sformatf("hold_cyc%0d", k), 3'b001, 8'hA0, 1, (k == 8), 0);
        cyc(0, 3'b000, 3'b000, "hold_cyc9",    3'b001, 8'hA0, 1, 1, 0);
        cyc(0, 3'b000, 3'b001, "late_release", 3'b001, 8'hA0, 1, 1, 0);
        cyc(0, 3'b000, 3'b000, "sticky_idle",  3'b000, 8'hA0, 0, 1, 0);
        // Async reset while locked
        cyc(0, 3'b010, 3'b000, "grant_ch1",    3'b010, 8'hA1, 0, 1, 0);
        cyc(1, 3'b010, 3'b000, "async_reset",  3'b000, 8'hA0, 0, 0, 0);
        cyc(0, 3'b011, 3'b000, "post_reset",   3'b001, 8'hA0, 0, 0, 0);
        // Fixed priority instance: channel 0 wins every time
        cyc(1, 3'b111, 3'b000, "fp_reset",     3'b000, 8'hA0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 3'b111, 3'b000, $sformatf("fp_grant%0d", k), 3'b001, 8'hA0, 0, 0, 1);
            cyc(0, 3'b111, 3'b001, $sformatf("fp_done%0d", k),  3'b001, 8'hA0, 1, 0, 1);
        end
        ch_req  = '0;
        ch_done = '0;
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
